kmer_gen_ctrl: RTL

Sequencer for the k-mer generator datapath (kmer_gen). It drives that datapath's EN_RG1/EN_SHIFT/EN_RG2/EN_OUT strobes.
- Upstream: accepts one 512-bit read per valid/ready handshake.
- Downstream: emits one k-mer per valid/ready handshake, with backpressure.
- Between reads: issues padding shifts so the datapath's free-running 8-bit position counter is back at 0 when the next read starts.
Sits between the read buffer and the k-mer hash/lookup stage.

---
 rtl/kmer_pkg.sv | 36 +++
 rtl/kmer_gen_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/kmer_pkg.sv
// Shared constants, state encoding and length arithmetic for the k-mer generator sequencer.
// Lengths are handled in LEN_W bits so that a full 256-base read is representable.
package kmer_pkg;

    localparam int K          = 45;
    localparam int READ_BASES = 256;
    localparam int CNT_W      = 8;
    localparam int LEN_W      = 9;
    localparam int KMER_BITS  = 2 * K;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        CAP,
        HOLD,
        ALIGN
    } state_e;

    typedef struct packed {
        logic [LEN_W-1:0] nk;
        logic [LEN_W-1:0] pad;
    } kmer_counts_t;

    // nk k-mers per read, then pad idle shifts so nk + pad wraps the datapath counter to 0.
    function automatic kmer_counts_t calc_counts(input logic [LEN_W-1:0] len);
        kmer_counts_t c;
        c.nk  = len - LEN_W'(K - 1);
        c.pad = LEN_W'(READ_BASES) - c.nk;
        return c;
    endfunction

    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len >= LEN_W'(K)) && (len <= LEN_W'(READ_BASES));
    endfunction

endpackage

// File: rtl/kmer_gen_ctrl.sv
// Sequencer for the kmer_gen datapath: loads a read, steps out one k-mer per
// downstream handshake, then pads shifts so the datapath counter is 0 for the next read.
module kmer_gen_ctrl
    import kmer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [LEN_W-1:0] rd_len,
    output logic             kg_en_rg1,
    output logic             kg_en_shift,
    output logic             kg_en_rg2,
    output logic             kg_en_out,
    output logic             kmer_valid,
    input  logic             kmer_ready,
    output logic [CNT_W-1:0] kmer_pos,
    output logic             kmer_last,
    output logic             len_err,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] last_idx_q, last_idx_d;
    logic [LEN_W-1:0] pad_q, pad_d;
    logic             len_err_q, len_err_d;
    kmer_counts_t     counts;
    logic             is_last;

    assign counts  = calc_counts(rd_len);
    assign is_last = (idx_q == last_idx_q);

    // NOTE: every output and next-state value gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_idx_d  = last_idx_q;
        pad_d       = pad_q;
        len_err_d   = 1'b0;
        rd_ready    = 1'b0;
        kg_en_rg1   = 1'b0;
        kg_en_shift = 1'b0;
        kg_en_rg2   = 1'b0;
        kg_en_out   = 1'b0;
        kmer_valid  = 1'b0;
        kmer_last   = 1'b0;

        unique case (state_q)
            IDLE: begin
                rd_ready = 1'b1;
                if (rd_valid) begin
                    // Datapath captures the read on this edge whatever its length.
                    kg_en_rg1 = 1'b1;
                    if (len_legal(rd_len)) begin
                        idx_d      = '0;
                        last_idx_d = CNT_W'(counts.nk - LEN_W'(1));
                        pad_d      = counts.pad;
                        state_d    = GEN;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            GEN: begin
                kg_en_rg2   = 1'b1;
                kg_en_shift = 1'b1;
                state_d     = CAP;
            end
            CAP: begin
                kg_en_out = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                kmer_valid = 1'b1;
                kmer_last  = is_last;
                if (kmer_ready) begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = is_last ? ALIGN : GEN;
                end
            end
            ALIGN: begin
                kg_en_shift = 1'b1;
                pad_d       = pad_q - LEN_W'(1);
                if (pad_q <= LEN_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset returns the sequencer to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            last_idx_q <= '0;
            pad_q      <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            pad_q      <= pad_d;
            len_err_q  <= len_err_d;
        end
    end

    assign kmer_pos = idx_q;
    assign len_err  = len_err_q;
    assign busy     = (state_q != IDLE);

endmodule
